// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : isa_pkg
// Brief    : Opcodes, mnemonic/format enums and loader states for the core ISA.
// Revision : 1.0
// ============================================================================
package isa_pkg;

  localparam logic [5:0] c_op_andr = 6'b100000;
  localparam logic [5:0] c_op_lw   = 6'b100011;
  localparam logic [5:0] c_op_sw   = 6'b101011;
  localparam logic [5:0] c_op_jr   = 6'b001000;
  localparam logic [5:0] c_op_jal  = 6'b000011;
  localparam logic [5:0] c_op_norr = 6'b100110;
  localparam logic [5:0] c_op_nori = 6'b001110;
  localparam logic [5:0] c_op_notr = 6'b000100;
  localparam logic [5:0] c_op_bleu = 6'b010000;
  localparam logic [5:0] c_op_rolv = 6'b000000;
  localparam logic [5:0] c_op_rorv = 6'b000010;

  typedef enum logic [3:0] {
    MN_ANDR = 4'd0,
    MN_LW   = 4'd1,
    MN_SW   = 4'd2,
    MN_JR   = 4'd3,
    MN_JAL  = 4'd4,
    MN_NORR = 4'd5,
    MN_NORI = 4'd6,
    MN_NOTR = 4'd7,
    MN_BLEU = 4'd8,
    MN_ROLV = 4'd9,
    MN_RORV = 4'd10
  } mnem_t;

  typedef enum logic [1:0] {
    FMT_R  = 2'd0,
    FMT_I  = 2'd1,
    FMT_J  = 2'd2,
    FMT_JR = 2'd3
  } fmt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Combinational mnemonic + fields to 32-bit instruction word.
// Revision : 1.0
// ============================================================================
module instr_encoder
  import isa_pkg::*;
(
  input  logic [3:0]  i_mnem,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [25:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  logic [5:0] w_op;
  logic [4:0] w_rt;
  fmt_t       w_fmt;

  always_comb begin
    w_op      = c_op_rolv;
    w_rt      = i_rt;
    w_fmt     = FMT_R;
    o_illegal = 1'b0;
    case (mnem_t'(i_mnem))
      MN_ANDR: w_op = c_op_andr;
      MN_NORR: w_op = c_op_norr;
      MN_ROLV: w_op = c_op_rolv;
      MN_RORV: w_op = c_op_rorv;
      MN_NOTR: begin w_op = c_op_notr; w_rt = 5'd0; end
      MN_LW:   begin w_op = c_op_lw;   w_fmt = FMT_I; end
      MN_SW:   begin w_op = c_op_sw;   w_fmt = FMT_I; end
      MN_NORI: begin w_op = c_op_nori; w_fmt = FMT_I; end
      MN_BLEU: begin w_op = c_op_bleu; w_fmt = FMT_I; end
      MN_JAL:  begin w_op = c_op_jal;  w_fmt = FMT_J; end
      MN_JR:   begin w_op = c_op_jr;   w_fmt = FMT_JR; end
      default: o_illegal = 1'b1;
    endcase
  end

  always_comb begin
    o_word = 32'd0;
    case (w_fmt)
      FMT_R:   o_word = {w_op, i_rs, w_rt, i_rd, 11'd0};
      FMT_I:   o_word = {w_op, i_rs, w_rt, i_imm[15:0]};
      FMT_J:   o_word = {w_op, i_imm};
      FMT_JR:  o_word = {w_op, i_rs, 21'd0};
      default: o_word = 32'd0;
    endcase
    if (o_illegal) o_word = 32'd0;
  end

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Brief    : Encodes handshaked instructions and writes them to imem from 0.
// Revision : 1.0
// ============================================================================
module instr_loader
  import isa_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] c_last_slot = (ADDR_W+1)'(DEPTH - 1);

  ld_state_t         r_state;
  ld_state_t         w_state_nxt;
  logic [ADDR_W:0]   r_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_accept;
  logic              w_write;

  instr_encoder u_enc (
    .i_mnem    (in_mnem),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_imm     (in_imm),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  assign w_accept = in_valid && (r_state == ST_LOAD);
  assign w_write  = w_accept && !w_illegal;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_accept) begin
          if (w_illegal)                 w_state_nxt = ST_ERR;
          else if (in_last)              w_state_nxt = ST_DONE;
          else if (r_count == c_last_slot) w_state_nxt = ST_ERR;
        end
      end
      default: if (start) w_state_nxt = ST_LOAD;
    endcase
  end

  // Start and accept are mutually exclusive: accept only happens in LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_write;
      if (w_write) begin
        r_addr  <= r_count[ADDR_W-1:0];
        r_wdata <= w_word;
        r_count <= r_count + (ADDR_W+1)'(1);
      end else if (start && r_state != ST_LOAD) begin
        r_count <= '0;
      end
    end
  end

  assign in_ready   = (r_state == ST_LOAD);
  assign busy       = (r_state == ST_LOAD);
  assign done       = (r_state == ST_DONE);
  assign err        = (r_state == ST_ERR);
  assign count      = r_count;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;

endmodule
`default_nettype wire
